snake_ctl: RTL
==============

SNAKE_CTL -- requirements
Module: snake_ctl

Interface
REQ-001 Parameter GRID_W, default 64: playfield width in cells; head_x range is 0..GRID_W-1.
REQ-002 Parameter GRID_H, default 48: playfield height in cells; head_y range is 0..GRID_H-1.
REQ-003 Parameter STEP_DIV, default 6_500_000: clk cycles per snake move step; legal values are 2 or more.
REQ-004 Port clk, input, 1 bit: the single clock; all state SHALL be clocked on its rising edge.
REQ-005 Port reset, input, 1 bit: reset is asynchronous and active-low.
REQ-006 Port start, input, 1 bit: level request to start or restart a game.
REQ-007 Port dir_valid, input, 1 bit: qualifies dir for one cycle.
REQ-008 Port dir, input, 2 bits: requested direction; 0=up, 1=right, 2=down, 3=left.
REQ-009 Port apple_x, input, 7 bits: apple cell column.
REQ-010 Port apple_y, input, 6 bits: apple cell row.
REQ-011 Port head_x, output, 7 bits: head cell column.
REQ-012 Port head_y, output, 6 bits: head cell row.
REQ-013 Port tail_x, output, 105 bits: 15 packed 7-bit segment columns; segment k occupies bits [7k+6:7k], and segment 0 is adjacent to the head.
REQ-014 Port tail_y, output, 90 bits: 15 packed 6-bit segment rows; segment k occupies bits [6k+5:6k].
REQ-015 Port score, output, 4 bits: count of active tail segments, 0..15.
REQ-016 Port apple_eaten, output, 1 bit: one-cycle pulse when the head lands on the apple.
REQ-017 Port game_over, output, 1 bit: high while in state OVER.

Function
REQ-018 The FSM SHALL have four states: IDLE, RUN, MOVE and OVER.
REQ-019 IDLE SHALL go to RUN on start=1; the step divider is cleared on entry to RUN.
REQ-020 In RUN, the divider SHALL count 0..STEP_DIV-1; at terminal count the FSM SHALL go to MOVE for exactly one cycle, then return to RUN or go to OVER.
REQ-021 In MOVE, the next head SHALL be the current head plus one cell in the committed direction.
REQ-022 Collision SHALL be either next head outside 0..GRID_W-1 / 0..GRID_H-1 (including decrement below 0), or next head equal to any segment k < score.
REQ-023 On collision: head, tail and score SHALL hold; the FSM SHALL go to OVER.
REQ-024 Otherwise, on the edge leaving MOVE: segment 0 takes the old head, segment k takes old segment k-1, and head takes the next head.
REQ-025 If the next head equals (apple_x, apple_y) and there is no collision, apple_eaten SHALL pulse in the cycle after MOVE.
REQ-026 On that apple hit, score SHALL increment, saturating at 15; at 15, apple_eaten still pulses.
REQ-027 Segments k ≥ score SHALL still shift but are ignored for collision detection.
REQ-028 Direction handling: a dir_valid in any state SHALL load the pending direction; the last valid request before MOVE wins.
REQ-029 In MOVE, the pending direction SHALL become the committed direction, unless it is the exact reverse of the committed direction, in which case it is discarded.
REQ-030 A dir_valid in the same cycle as MOVE SHALL apply to the next step, not the current one.
REQ-031 In OVER, outputs SHALL hold and game_over=1.
REQ-032 start=1 in OVER SHALL reinitialise to reset values and go to RUN directly.
REQ-033 start SHALL be ignored in RUN and MOVE.
REQ-034 Output latency: head, tail and score SHALL change exactly STEP_DIV+1 cycles after RUN entry for the first step, and every STEP_DIV+1 cycles thereafter.

Reset
REQ-035 While reset=0, all state SHALL be cleared asynchronously: state=IDLE, divider=0, head_x=GRID_W/2, head_y=GRID_H/2.
REQ-036 Reset values SHALL also include committed and pending direction = right, tail_x=0, tail_y=0, score=0, apple_eaten=0 and game_over=0.
REQ-037 Reset asserted mid-MOVE SHALL abort the step with no partial update.
REQ-038 Reset release SHALL be synchronised by the system; the block itself adds no synchroniser.

Structure
REQ-039 Shared package snake_pkg SHALL hold the direction encoding, the segment widths (7/6), the maximum tail length (15) and the default GRID_W/GRID_H.
REQ-040 The step divider SHALL be a sub-module named step_timer, with inputs clk, reset, clear and outputs tick.
REQ-041 Collision detection SHALL be combinational within the MOVE cycle, with no extra pipeline stage.

Verification
REQ-042 Scenario: reset, start, STEP_DIV=4, no dir → head_x goes 32→33→34 every 5 cycles, head_y=24, score=0.
REQ-043 Scenario: apple at (33,24) → apple_eaten pulses once, score=1, tail segment 0=(32,24); next step segment 0=(33,24).
REQ-044 Scenario: heading right, dir=left then dir=up in the same step → up is committed; dir=left alone → ignored, direction stays right.
REQ-045 Scenario: head at (63,y) heading right → OVER, game_over=1, head stays (63,y); head at (0,y) heading left → OVER.
REQ-046 Scenario: score=4, path up,left,down into own body → OVER on self-hit; a segment with index ≥ score at the same cell → no collision.
REQ-047 Scenario: 16 apples → score saturates at 15, apple_eaten pulses 16 times; start in OVER → reset values, RUN; reset mid-RUN → all outputs at reset values immediately.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared definitions for the snake game controller.
//   - dir_e    : direction encoding carried on the dir input
//   - state_e  : controller FSM states
//   - segment geometry (column/row widths, tail length) and default grid size
//   - is_reverse() : true when two directions point in opposite senses
package snake_pkg;

   typedef enum logic [1:0] {
      DirUp    = 2'd0,
      DirRight = 2'd1,
      DirDown  = 2'd2,
      DirLeft  = 2'd3
   } dir_e;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StMove,
      StOver
   } state_e;

   localparam int unsigned SegXW    = 7;
   localparam int unsigned SegYW    = 6;
   localparam int unsigned MaxTail  = 15;
   localparam int unsigned ScoreW   = 4;
   localparam int unsigned TailXW   = SegXW * MaxTail;
   localparam int unsigned TailYW   = SegYW * MaxTail;
   localparam int unsigned DefGridW = 64;
   localparam int unsigned DefGridH = 48;

   // Opposite directions differ only in bit 1 of the encoding.
   function automatic logic is_reverse(input dir_e a, input dir_e b);
      logic [1:0] diff;
      diff = 2'(a) ^ 2'(b);
      return diff == 2'b10;
   endfunction

endpackage

// File: rtl/snake_ctl_step_timer.sv
// step_timer: free-running step divider for the snake controller.
//   clk   : clock, rising edge
//   reset : asynchronous, active-low
//   clear : holds the count at zero while high
//   tick  : high during the last cycle (count == STEP_DIV-1) of each period
module step_timer #(
   parameter int unsigned STEP_DIV = 6_500_000
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   localparam int unsigned CntW = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(STEP_DIV - 1);

   logic [CntW-1:0] cnt_q;

   assign tick = !clear && (cnt_q == LastCnt);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else if (clear || tick) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + CntW'(1);
      end
   end

endmodule

// File: rtl/snake_ctl.sv
// snake_ctl: movement, growth and collision control for a grid snake game.
//   clk          : clock, rising edge
//   reset        : asynchronous, active-low
//   start        : level request to start (IDLE) or restart (OVER) a game
//   dir_valid    : qualifies dir for one cycle
//   dir          : requested direction (0 up, 1 right, 2 down, 3 left)
//   apple_x/y    : apple cell
//   head_x/y     : head cell
//   tail_x/y     : 15 packed segments, segment 0 next to the head
//   score        : number of live tail segments (0..15)
//   apple_eaten  : one-cycle pulse after a step that lands on the apple
//   game_over    : high while the game is over
module snake_ctl
   import snake_pkg::*;
#(
   parameter int unsigned GRID_W   = DefGridW,
   parameter int unsigned GRID_H   = DefGridH,
   parameter int unsigned STEP_DIV = 6_500_000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              dir_valid,
   input  logic [1:0]        dir,
   input  logic [SegXW-1:0]  apple_x,
   input  logic [SegYW-1:0]  apple_y,
   output logic [SegXW-1:0]  head_x,
   output logic [SegYW-1:0]  head_y,
   output logic [TailXW-1:0] tail_x,
   output logic [TailYW-1:0] tail_y,
   output logic [ScoreW-1:0] score,
   output logic              apple_eaten,
   output logic              game_over
);

   localparam logic [SegXW-1:0]  MaxX     = SegXW'(GRID_W - 1);
   localparam logic [SegYW-1:0]  MaxY     = SegYW'(GRID_H - 1);
   localparam logic [SegXW-1:0]  StartX   = SegXW'(GRID_W / 2);
   localparam logic [SegYW-1:0]  StartY   = SegYW'(GRID_H / 2);
   localparam logic [ScoreW-1:0] ScoreMax = ScoreW'(MaxTail);

   state_e              state_q;
   dir_e                cur_dir_q;
   dir_e                pend_dir_q;
   logic [SegXW-1:0]    head_x_q;
   logic [SegYW-1:0]    head_y_q;
   logic [TailXW-1:0]   tail_x_q;
   logic [TailYW-1:0]   tail_y_q;
   logic [ScoreW-1:0]   score_q;
   logic                apple_eaten_q;
   logic                game_over_q;

   logic                timer_clear;
   logic                step_tick;

   dir_e                eff_dir;
   logic [SegXW-1:0]    next_x;
   logic [SegYW-1:0]    next_y;
   logic                out_of_grid;
   logic                self_hit;
   logic                collide;
   logic                apple_hit;

   // Divider only runs in RUN, so it restarts from zero on every entry to RUN.
   assign timer_clear = (state_q != StRun);

   step_timer #(
      .STEP_DIV(STEP_DIV)
   ) u_step_timer (
      .clk   (clk),
      .reset (reset),
      .clear (timer_clear),
      .tick  (step_tick)
   );

   // Next head and collision, evaluated combinationally during MOVE.
   always_comb begin
      eff_dir     = is_reverse(pend_dir_q, cur_dir_q) ? cur_dir_q : pend_dir_q;
      next_x      = head_x_q;
      next_y      = head_y_q;
      out_of_grid = 1'b0;
      unique case (eff_dir)
         DirUp: begin
            out_of_grid = (head_y_q == '0);
            next_y      = head_y_q - SegYW'(1);
         end
         DirRight: begin
            out_of_grid = (head_x_q >= MaxX);
            next_x      = head_x_q + SegXW'(1);
         end
         DirDown: begin
            out_of_grid = (head_y_q >= MaxY);
            next_y      = head_y_q + SegYW'(1);
         end
         DirLeft: begin
            out_of_grid = (head_x_q == '0);
            next_x      = head_x_q - SegXW'(1);
         end
         default: begin
            out_of_grid = 1'b0;
         end
      endcase

      // Only the first 'score' segments are body; the rest are stale history.
      self_hit = 1'b0;
      for (int k = 0; k < int'(MaxTail); k++) begin
         if ((ScoreW'(k) < score_q) &&
             (tail_x_q[k*SegXW +: SegXW] == next_x) &&
             (tail_y_q[k*SegYW +: SegYW] == next_y)) begin
            self_hit = 1'b1;
         end
      end

      collide   = out_of_grid || self_hit;
      apple_hit = !collide && (next_x == apple_x) && (next_y == apple_y);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= StIdle;
         cur_dir_q     <= DirRight;
         pend_dir_q    <= DirRight;
         head_x_q      <= StartX;
         head_y_q      <= StartY;
         tail_x_q      <= '0;
         tail_y_q      <= '0;
         score_q       <= '0;
         apple_eaten_q <= 1'b0;
         game_over_q   <= 1'b0;
      end else begin
         apple_eaten_q <= 1'b0;
         // A request during MOVE lands here after the commit below has
         // sampled the old pending value, so it only affects the next step.
         if (dir_valid) begin
            pend_dir_q <= dir_e'(dir);
         end

         unique case (state_q)
            StIdle: begin
               if (start) begin
                  state_q <= StRun;
               end
            end

            StRun: begin
               if (step_tick) begin
                  state_q <= StMove;
               end
            end

            StMove: begin
               cur_dir_q <= eff_dir;
               if (collide) begin
                  state_q     <= StOver;
                  game_over_q <= 1'b1;
               end else begin
                  state_q  <= StRun;
                  head_x_q <= next_x;
                  head_y_q <= next_y;
                  tail_x_q <= {tail_x_q[TailXW-SegXW-1:0], head_x_q};
                  tail_y_q <= {tail_y_q[TailYW-SegYW-1:0], head_y_q};
                  if (apple_hit) begin
                     apple_eaten_q <= 1'b1;
                     if (score_q != ScoreMax) begin
                        score_q <= score_q + ScoreW'(1);
                     end
                  end
               end
            end

            StOver: begin
               // Restart goes straight to RUN with a fresh game.
               if (start) begin
                  state_q       <= StRun;
                  cur_dir_q     <= DirRight;
                  pend_dir_q    <= DirRight;
                  head_x_q      <= StartX;
                  head_y_q      <= StartY;
                  tail_x_q      <= '0;
                  tail_y_q      <= '0;
                  score_q       <= '0;
                  apple_eaten_q <= 1'b0;
                  game_over_q   <= 1'b0;
               end
            end

            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign head_x      = head_x_q;
   assign head_y      = head_y_q;
   assign tail_x      = tail_x_q;
   assign tail_y      = tail_y_q;
   assign score       = score_q;
   assign apple_eaten = apple_eaten_q;
   assign game_over   = game_over_q;

endmodule
